// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and its seven-segment display decoder.
package bin_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

    // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_lookup(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_seg7.sv
// One-digit BCD to active-low seven-segment decoder with a blanking input;
// non-decimal codes 10-15 show blank.
module seg7_decoder
    import bin_bcd_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the digit pattern.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_lookup(code);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done.
// Optional HEX display outputs are built when BIN_BCD_SEG_EN is defined.
module bin_to_bcd_seq
    import bin_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BIN_BCD_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   HEX
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [WIDTH-1:0] opnd_r;
    logic [SW-1:0]   scr_r;
    logic            sticky_r;
    logic [SW-1:0]   bcd_r;
    logic            ovf_r;

    logic [SW-1:0]   adj_s;
    logic [SW-1:0]   scr_nxt_s;
    logic            out_bit_s;
    logic            last_s;
    logic            accept_s;
    logic            busy_s;
    logic            done_s;

    // Add-3 correction per digit; digits are independent 4-bit adds.
    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        assign adj_s[4*d +: 4] = (scr_r[4*d +: 4] >= BCD_ADD3_THRESH)
                               ? (scr_r[4*d +: 4] + 4'd3)
                               : scr_r[4*d +: 4];
    end

    assign out_bit_s = adj_s[SW-1];
    assign scr_nxt_s = {adj_s[SW-2:0], opnd_r[WIDTH-1]};
    assign last_s    = (cnt_r == CW'(1));
    assign accept_s  = start && ((state_r == IDLE) || (state_r == DONE));

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start)  state_s = SHIFT; else state_s = IDLE;
            SHIFT:   if (last_s) state_s = DONE;  else state_s = SHIFT;
            DONE:    if (start)  state_s = SHIFT; else state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
            SHIFT:   begin busy_s = 1'b1; done_s = 1'b0; end
            DONE:    begin busy_s = 1'b0; done_s = 1'b1; end
            default: begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // Datapath: load on accept, shift while SHIFT, publish result on the last shift.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            cnt_r    <= '0;
            opnd_r   <= '0;
            scr_r    <= '0;
            sticky_r <= 1'b0;
            bcd_r    <= '0;
            ovf_r    <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= CW'(WIDTH);
            opnd_r   <= bin;
            scr_r    <= '0;
            sticky_r <= 1'b0;
        end else if (state_r == SHIFT) begin
            cnt_r    <= cnt_r - CW'(1);
            opnd_r   <= opnd_r << 1;
            scr_r    <= scr_nxt_s;
            sticky_r <= sticky_r | out_bit_s;
            if (last_s) begin
                bcd_r <= scr_nxt_s;
                ovf_r <= sticky_r | out_bit_s;
            end
        end
    end

    assign busy = busy_s;
    assign done = done_s;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

`ifdef BIN_BCD_SEG_EN
    // Leading-zero blanking: a digit blanks when it and every digit above are zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_seg
        logic blank_s;
        if (k == 0) begin : g_units
            assign blank_s = 1'b0;
        end else begin : g_upper
            assign blank_s = ~(|bcd_r[SW-1:4*k]);
        end
        seg7_decoder u_seg (
            .code  (bcd_r[4*k +: 4]),
            .blank (blank_s),
            .seg   (HEX[7*k +: 7])
        );
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three instances (8/3, 16/5, 8/2),
// directed vectors, per-instance monitors popping expected results on done.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic s8, s16, s2;
    logic [7:0]  b8, b2;
    logic [15:0] b16;
    logic busy8, done8, ovf8, busy16, done16, ovf16, busy2, done2, ovf2;
    logic [11:0] bcd8;
    logic [19:0] bcd16;
    logic [7:0]  bcd2;
`ifdef BIN_BCD_SEG_EN
    logic [20:0] hex8;
    logic [34:0] hex16;
    logic [13:0] hex2;
`endif

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .CLOCK_50(clk), .Resetn(rstn), .start(s8), .bin(b8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
`ifdef BIN_BCD_SEG_EN
        , .HEX(hex8)
`endif
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .CLOCK_50(clk), .Resetn(rstn), .start(s16), .bin(b16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16)
`ifdef BIN_BCD_SEG_EN
        , .HEX(hex16)
`endif
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .CLOCK_50(clk), .Resetn(rstn), .start(s2), .bin(b2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
`ifdef BIN_BCD_SEG_EN
        , .HEX(hex2)
`endif
    );

    int npass = 0;
    int ntot  = 0;
    logic [12:0] q8[$];
    logic [20:0] q16[$];
    logic [8:0]  q2[$];
    logic [12:0] e8;
    logic [20:0] e16;
    logic [8:0]  e2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic cur_done(input int sel);
        if (sel == 0) return done8;
        else if (sel == 1) return done16;
        else return done2;
    endfunction

    // Counts negedges until the selected done is seen; 40 means it never came.
    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (cyc < 40 && cur_done(sel) !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Monitors: every done pops one expectation {ovf, bcd}.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("bcd8", 32'(bcd8), 32'(e8[11:0]));
                chk("ovf8", 32'(ovf8), 32'(e8[12]));
                chk("busy_with_done8", 32'(busy8), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
            else begin
                e16 = q16.pop_front();
                chk("bcd16", 32'(bcd16), 32'(e16[19:0]));
                chk("ovf16", 32'(ovf16), 32'(e16[20]));
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                chk("bcd2", 32'(bcd2), 32'(e2[7:0]));
                chk("ovf2", 32'(ovf2), 32'(e2[8]));
            end
        end
    end

    // One conversion on the 8/3 instance with full timing check; bin is
    // scrambled after acceptance to show it is not resampled.
    task automatic run8(input logic [7:0] v, input logic [11:0] e, input logic eo);
        int nb;
        b8 = v; s8 = 1'b1;
        q8.push_back({eo, e});
        @(negedge clk);
        s8 = 1'b0; b8 = ~v;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy8 === 1'b1 && done8 === 1'b0) nb++;
            @(negedge clk);
        end
        chk("busy_window8", 32'(nb), 32'd8);
        chk("done_at_T+9", 32'(done8), 32'd1);
    endtask

    task automatic run2(input logic [7:0] v, input logic [7:0] e, input logic eo);
        int c;
        b2 = v; s2 = 1'b1;
        q2.push_back({eo, e});
        @(negedge clk);
        s2 = 1'b0;
        wait_done(2, c);
        chk("latency2", 32'(c), 32'd8);
        @(negedge clk);
    endtask

    initial begin
        int c;
        rstn = 1'b0; s8 = 1'b0; s16 = 1'b0; s2 = 1'b0;
        b8 = 8'd0; b16 = 16'd0; b2 = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_bcd",  32'(bcd8),  32'd0);
        chk("rst_ovf",  32'(ovf8),  32'd0);
`ifdef BIN_BCD_SEG_EN
        chk("rst_hex", 32'(hex8), 32'({7'b1111111, 7'b1111111, 7'b0000001}));
`endif
        rstn = 1'b1;
        @(negedge clk);

        run8(8'd255, 12'h255, 1'b0);
`ifdef BIN_BCD_SEG_EN
        chk("hex_255", 32'(hex8), 32'({7'b0010010, 7'b0100100, 7'b0100100}));
`endif
        @(negedge clk);
        run8(8'd0, 12'h000, 1'b0);
`ifdef BIN_BCD_SEG_EN
        chk("hex_0", 32'(hex8), 32'({7'b1111111, 7'b1111111, 7'b0000001}));
`endif
        @(negedge clk);
        run8(8'd1,   12'h001, 1'b0); @(negedge clk);
        run8(8'd59,  12'h059, 1'b0); @(negedge clk);
        run8(8'd128, 12'h128, 1'b0); @(negedge clk);

        // start held high across DONE: back-to-back conversions of 7
        b8 = 8'd7; s8 = 1'b1;
        q8.push_back({1'b0, 12'h007});
        q8.push_back({1'b0, 12'h007});
        @(negedge clk);
        wait_done(0, c);
        chk("held_first_latency", 32'(c), 32'd8);
`ifdef BIN_BCD_SEG_EN
        chk("hex_7", 32'(hex8), 32'({7'b1111111, 7'b1111111, 7'b0001111}));
`endif
        @(negedge clk);
        s8 = 1'b0;
        wait_done(0, c);
        chk("held_interval", 32'(c + 1), 32'd9);
        repeat (12) @(negedge clk);

        // start re-pulsed mid-SHIFT is ignored
        b8 = 8'd200; s8 = 1'b1;
        q8.push_back({1'b0, 12'h200});
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        b8 = 8'd99; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        wait_done(0, c);
        chk("repulse_latency", 32'(c), 32'd5);
        repeat (12) @(negedge clk);

        // reset mid-conversion aborts and clears the held result
        b8 = 8'd123; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_bcd",  32'(bcd8),  32'd0);
        rstn = 1'b1;
        repeat (14) @(negedge clk);

        // reset wins over start
        rstn = 1'b0; s8 = 1'b1; b8 = 8'd5;
        @(negedge clk);
        chk("rst_over_start", 32'(busy8), 32'd0);
        rstn = 1'b1; s8 = 1'b0;
        @(negedge clk);
        chk("rst_over_start_idle", 32'(busy8), 32'd0);

        // wide instance
        b16 = 16'd65535; s16 = 1'b1;
        q16.push_back({1'b0, 20'h65535});
        @(negedge clk);
        s16 = 1'b0;
        wait_done(1, c);
        chk("latency16", 32'(c), 32'd16);
        @(negedge clk);

        // two-digit instance: overflow and in-range
        run2(8'd100, 8'h00, 1'b1);
        run2(8'd99,  8'h99, 1'b0);
        run2(8'd255, 8'h55, 1'b1);

        repeat (4) @(negedge clk);
        chk("q8_drained",  32'(q8.size()),  32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        chk("q2_drained",  32'(q2.size()),  32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
